// File: rtl/recompositor_pkg.sv
// recompositor_pkg: shared FSM encoding and magnitude helper for the dividend rebuilder.
//   estado_t : IDLE / CALC / FIX controller states
//   MAX_W    : widest operand abs_mag can take (callers sign-extend into it)
//   abs_mag  : unsigned magnitude of a sign-extended two's complement value
package recompositor_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX} estado_t;

    localparam int MAX_W = 64;

    // The most-negative input maps to 2^(w-1), which still fits unsigned in w bits.
    function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] value);
        return value[MAX_W-1] ? -value : value;
    endfunction

endpackage

// File: rtl/recompositor_division_acumulador.sv
// acumulador_shift_add: LSB-first shift-add multiplier datapath.
//   clk, rst       : clock, synchronous active-high clear
//   load           : capture operands and clear the accumulator
//   step           : consume one multiplier bit
//   multiplicador  : unsigned multiplier (consumed LSB first)
//   multiplicando  : unsigned multiplicand
//   acc            : 2*size running product
module acumulador_shift_add #(
    parameter int size = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [size-1:0]   multiplicador,
    input  logic [size-1:0]   multiplicando,
    output logic [2*size-1:0] acc
);

    logic [2*size-1:0] mcand;
    logic [size-1:0]   mplier;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{size{1'b0}}, multiplicando};
            mplier <= multiplicador;
        end else if (step) begin
            acc    <= mplier[0] ? acc + mcand : acc;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/recompositor_division.sv
// recompositor_division: rebuilds numerador = cociente*denominador + resto and flags legal triples.
//   clk, rst                      : clock, synchronous active-high reset
//   start                         : request, sampled only in IDLE
//   cociente, denominador, resto  : signed size-bit triple
//   numerador                     : signed 2*size rebuilt dividend, held until next result
//   coherente                     : triple is a legal division result (valid with done)
//   busy                          : accept edge through done edge inclusive
//   done                          : one-cycle result-valid pulse
module recompositor_division
    import recompositor_pkg::*;
#(
    parameter int size = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [size-1:0]   cociente,
    input  logic [size-1:0]   denominador,
    input  logic [size-1:0]   resto,
    output logic [2*size-1:0] numerador,
    output logic              coherente,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(size);
    localparam int W2    = 2 * size;

    estado_t           estado, estado_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              load, step, fix, last;
    logic              sgn;
    logic [W2-1:0]     resto_ext, acc, num_nxt;
    logic [size-1:0]   mag_c_in, mag_d_in, mag_r_in, mag_d, mag_r;
    logic              coh_nxt;

    assign mag_c_in = size'(abs_mag(MAX_W'($signed(cociente))));
    assign mag_d_in = size'(abs_mag(MAX_W'($signed(denominador))));
    assign mag_r_in = size'(abs_mag(MAX_W'($signed(resto))));
    assign last     = cnt == CNT_W'(size - 1);

    acumulador_shift_add #(.size(size)) u_acc (
        .clk           (clk),
        .rst           (rst),
        .load          (load),
        .step          (step),
        .multiplicador (mag_c_in),
        .multiplicando (mag_d_in),
        .acc           (acc)
    );

    always_ff @(posedge clk) begin
        if (rst) estado <= IDLE;
        else     estado <= estado_nxt;
    end

    always_comb begin
        estado_nxt = (estado == IDLE) ? (start ? CALC : IDLE) :
                     (estado == CALC) ? (last ? FIX : CALC) : IDLE;
    end

    always_comb begin
        load = (estado == IDLE) && start;
        step = estado == CALC;
        fix  = estado == FIX;
    end

    // Magnitudes are unsigned so a -2^(size-1) remainder or divisor compares correctly.
    assign num_nxt = (sgn ? -acc : acc) + resto_ext;
    assign coh_nxt = (mag_d != '0) && (mag_r < mag_d) &&
                     ((resto_ext == '0) || (resto_ext[W2-1] == num_nxt[W2-1]));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            sgn       <= 1'b0;
            resto_ext <= '0;
            mag_d     <= '0;
            mag_r     <= '0;
            numerador <= '0;
            coherente <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= fix;
            busy <= load | step | fix;
            if (load) begin
                cnt       <= '0;
                sgn       <= cociente[size-1] ^ denominador[size-1];
                resto_ext <= W2'($signed(resto));
                mag_d     <= mag_d_in;
                mag_r     <= mag_r_in;
            end
            if (step) cnt <= cnt + 1'b1;
            if (fix) begin
                numerador <= num_nxt;
                coherente <= coh_nxt;
            end
        end
    end

endmodule

// File: tb/tb_recompositor_division.sv
// tb_recompositor_division: directed and randomized checks against an arithmetic reference.
module tb_recompositor_division;

    localparam int SZ = 8;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [SZ-1:0] cociente, denominador, resto;
    logic [2*SZ-1:0] numerador;
    logic          coherente, busy, done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    recompositor_division #(.size(SZ)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cociente    (cociente),
        .denominador (denominador),
        .resto       (resto),
        .numerador   (numerador),
        .coherente   (coherente),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    function automatic void model(input int c, input int d, input int r,
                                  output longint n, output logic coh);
        longint p;
        p   = longint'(c) * d + r;
        n   = p & 64'hFFFF;
        coh = (d != 0) && (iabs(r) < iabs(d)) && (r == 0 || ((r < 0) == (p < 0)));
    endfunction

    task automatic set_ops(input int c, input int d, input int r);
        cociente    = SZ'(c);
        denominador = SZ'(d);
        resto       = SZ'(r);
    endtask

    task automatic op(input int c, input int d, input int r, input bit chk_busy);
        longint en;
        logic   ec;
        int     n;
        model(c, d, r, en, ec);
        set_ops(c, d, r);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        check("latency", n, SZ + 1);
        check("numerador", longint'(numerador), en);
        check("coherente", longint'(coherente), longint'(ec));
        if (chk_busy) begin
            check("busy_at_done", longint'(busy), 1);
            @(posedge clk);
            #1;
            check("busy_after", longint'(busy), 0);
            check("done_pulse", longint'(done), 0);
        end
    endtask

    initial begin
        longint en;
        logic   ec;
        int     dn, at, prev, q, dd, nn;
        rst = 1'b1;
        start = 1'b0;
        set_ops(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_num", longint'(numerador), 0);
        check("rst_coh", longint'(coherente), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        rst = 1'b0;

        op(7, 3, 2, 1);
        op(-7, 3, -2, 1);
        check("neg23_hex", longint'(numerador), 64'hFFE9);
        op(-7, -3, 2, 1);
        op(-128, -128, 0, 1);
        op(127, -128, 5, 1);
        op(5, 0, 9, 1);
        op(2, 3, 3, 1);

        // second start mid-operation must be ignored
        model(10, 5, 3, en, ec);
        set_ops(10, 5, 3);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dn = 0;
        at = 0;
        for (int i = 1; i <= 15; i++) begin
            if (i == 3) begin
                set_ops(-3, 7, 1);
                start = 1'b1;
            end
            if (i == 4) start = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                dn++;
                at = i;
                check("ign_num", longint'(numerador), en);
                check("ign_coh", longint'(coherente), longint'(ec));
            end
        end
        check("ign_done_cnt", dn, 1);
        check("ign_done_at", at, SZ + 1);

        // start held high: one result every SZ+2 clocks
        model(-11, 9, -4, en, ec);
        set_ops(-11, 9, -4);
        start = 1'b1;
        prev = -1;
        dn = 0;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (prev >= 0) check("held_period", i - prev, SZ + 2);
                check("held_num", longint'(numerador), en);
                prev = i;
                dn++;
            end
        end
        start = 1'b0;
        check("held_count", dn, 4);
        repeat (12) @(posedge clk);
        #1;

        // reset mid-CALC
        set_ops(9, 4, 1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_num", longint'(numerador), 0);
        check("mid_rst_coh", longint'(coherente), 0);
        check("mid_rst_busy", longint'(busy), 0);
        check("mid_rst_done", longint'(done), 0);
        rst = 1'b0;
        dn = 0;
        repeat (12) begin
            @(posedge clk);
            #1 if (done) dn++;
        end
        check("mid_rst_no_done", dn, 0);
        op(9, 4, 1, 1);

        // legal triples from a golden truncating divider
        for (int i = 0; i < 3000; i++) begin
            nn = int'($urandom_range(0, 255)) - 128;
            dd = int'($urandom_range(0, 255)) - 128;
            if (dd == 0 || (nn == -128 && dd == -1)) dd = 3;
            q = nn / dd;
            op(q, dd, nn % dd, 0);
            check("sweep_dividend", longint'(numerador), longint'(nn) & 64'hFFFF);
            check("sweep_coh", longint'(coherente), 1);
        end

        // arbitrary triples, legal or not
        for (int i = 0; i < 500; i++) begin
            op(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
               int'($urandom_range(0, 255)) - 128, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
